// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_ctrl
// Purpose  : Match sequencer for the Pong datapath. Tracks game state, both
//            scores, the winner and serve direction. Gates the paddle and
//            ball blocks, and counts frame ticks for the serve and point delays.
// Ports    : in_clk      - pixel clock
//            reset       - asynchronous active-low reset
//            start_n     - start button, active-low, asynchronous
//            pause_n     - pause button, active-low, asynchronous
//            frame_tick  - one pulse per video frame
//            miss_left   - ball left the screen on the left (player 1 missed)
//            miss_right  - ball left the screen on the right (player 2 missed)
//            ball_rst    - hold the ball at screen centre
//            ball_run    - ball may advance
//            serve_dir   - 0 = launch toward player 1, 1 = toward player 2
//            paddle_en   - paddles may move
//            score1/2    - player scores
//            winner      - 0 none, 1 player 1, 2 player 2
//            game_state  - current state code
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int SCORE_W      = 4
) (
  input  logic               in_clk,
  input  logic               reset,
  input  logic               start_n,
  input  logic               pause_n,
  input  logic               frame_tick,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_rst,
  output logic               ball_run,
  output logic               serve_dir,
  output logic               paddle_en,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic [2:0]         game_state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;

  localparam logic [CNT_W-1:0]   C_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   C_POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0]   C_CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] C_WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] C_SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_POINT  = 3'd3,
    S_PAUSED = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  // Button synchronisers: bit 0 is the first flop, bit 2 the last.
  logic [2:0]         r_start_sync;
  logic [2:0]         r_pause_sync;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic [1:0]         r_winner;
  logic               r_serve_dir;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SCORE_W-1:0] w_score1_nxt;
  logic [SCORE_W-1:0] w_score2_nxt;
  logic [1:0]         w_winner_nxt;
  logic               w_serve_dir_nxt;

  logic               w_start_ev;
  logic               w_pause_ev;

  // High-to-low transition seen between the last two synchroniser stages,
  // so a held button yields a single event.
  assign w_start_ev = r_start_sync[2] & ~r_start_sync[1];
  assign w_pause_ev = r_pause_sync[2] & ~r_pause_sync[1];

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      r_start_sync <= 3'b111;
      r_pause_sync <= 3'b111;
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_winner     <= 2'd0;
      r_serve_dir  <= 1'b1;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start_n};
      r_pause_sync <= {r_pause_sync[1:0], pause_n};
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_score1     <= w_score1_nxt;
      r_score2     <= w_score2_nxt;
      r_winner     <= w_winner_nxt;
      r_serve_dir  <= w_serve_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_score1_nxt    = r_score1;
    w_score2_nxt    = r_score2;
    w_winner_nxt    = r_winner;
    w_serve_dir_nxt = r_serve_dir;

    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_ev) begin
          w_state_nxt     = S_SERVE;
          w_cnt_nxt       = '0;
          w_score1_nxt    = '0;
          w_score2_nxt    = '0;
          w_winner_nxt    = 2'd0;
          w_serve_dir_nxt = 1'b1;
        end
      end

      S_SERVE: begin
        if (frame_tick) begin
          if (r_cnt == C_SERVE_LAST) begin
            w_state_nxt = S_PLAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
      end

      S_PLAY: begin
        // A miss always takes priority over a pause edge in the same cycle.
        if (miss_left && miss_right) begin
          w_state_nxt = S_POINT;
          w_cnt_nxt   = '0;
        end else if (miss_left) begin
          w_state_nxt     = S_POINT;
          w_cnt_nxt       = '0;
          w_score2_nxt    = r_score2 + C_SCORE_ONE;
          w_serve_dir_nxt = 1'b0;
        end else if (miss_right) begin
          w_state_nxt     = S_POINT;
          w_cnt_nxt       = '0;
          w_score1_nxt    = r_score1 + C_SCORE_ONE;
          w_serve_dir_nxt = 1'b1;
        end else if (w_pause_ev) begin
          w_state_nxt = S_PAUSED;
        end
      end

      S_PAUSED: begin
        if (w_pause_ev) begin
          w_state_nxt = S_PLAY;
        end
      end

      S_POINT: begin
        if (frame_tick) begin
          if (r_cnt == C_POINT_LAST) begin
            w_cnt_nxt = '0;
            if (r_score1 == C_WIN) begin
              w_winner_nxt = 2'd1;
              w_state_nxt  = S_OVER;
            end else if (r_score2 == C_WIN) begin
              w_winner_nxt = 2'd2;
              w_state_nxt  = S_OVER;
            end else begin
              w_state_nxt = S_SERVE;
            end
          end else begin
            w_cnt_nxt = r_cnt + C_CNT_ONE;
          end
        end
      end

      // Unused codes fall back to IDLE.
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign ball_rst   = (r_state == S_IDLE) || (r_state == S_SERVE) || (r_state == S_OVER);
  assign ball_run   = (r_state == S_PLAY);
  assign paddle_en  = (r_state == S_SERVE) || (r_state == S_PLAY);
  assign serve_dir  = r_serve_dir;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign winner     = r_winner;
  assign game_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_game_ctrl
// Purpose  : Self-checking bench for pong_game_ctrl: a directed vector table,
//            a few hand-written corner sequences, then random play checked
//            against a frame-countdown reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

  localparam int WIN_SCORE    = 2;
  localparam int SERVE_FRAMES = 3;
  localparam int POINT_FRAMES = 2;
  localparam int SCORE_W      = 4;

  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_PAUSED = 4, M_OVER = 5;

  logic               in_clk = 1'b0;
  logic               reset;
  logic               start_n, pause_n, frame_tick, miss_left, miss_right;
  logic               ball_rst, ball_run, serve_dir, paddle_en;
  logic [SCORE_W-1:0] score1, score2;
  logic [1:0]         winner;
  logic [2:0]         game_state;

  pong_game_ctrl #(
    .WIN_SCORE   (WIN_SCORE),
    .SERVE_FRAMES(SERVE_FRAMES),
    .POINT_FRAMES(POINT_FRAMES),
    .SCORE_W     (SCORE_W)
  ) dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .start_n   (start_n),
    .pause_n   (pause_n),
    .frame_tick(frame_tick),
    .miss_left (miss_left),
    .miss_right(miss_right),
    .ball_rst  (ball_rst),
    .ball_run  (ball_run),
    .serve_dir (serve_dir),
    .paddle_en (paddle_en),
    .score1    (score1),
    .score2    (score2),
    .winner    (winner),
    .game_state(game_state)
  );

  always #5 in_clk = ~in_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  int m_state, m_s1, m_s2, m_win, m_left;
  bit m_sd;
  bit hs[3];   // start_n samples, [0] newest
  bit hp[3];

  task automatic model_reset();
    m_state = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_sd = 1; m_left = 0;
    for (int i = 0; i < 3; i++) begin hs[i] = 1; hp[i] = 1; end
  endtask

  // A button press takes effect two edges after its first low sample.
  task automatic model_edge();
    bit st_ev, pa_ev;
    if (reset !== 1'b1) return;
    st_ev = (hs[1] == 0) && (hs[2] == 1);
    pa_ev = (hp[1] == 0) && (hp[2] == 1);
    case (m_state)
      M_IDLE, M_OVER:
        if (st_ev) begin
          m_state = M_SERVE; m_s1 = 0; m_s2 = 0; m_win = 0; m_sd = 1; m_left = SERVE_FRAMES;
        end
      M_SERVE:
        if (frame_tick) begin
          m_left--;
          if (m_left == 0) m_state = M_PLAY;
        end
      M_PLAY:
        if (miss_left || miss_right) begin
          if (miss_left && !miss_right) begin m_s2++; m_sd = 0; end
          if (miss_right && !miss_left) begin m_s1++; m_sd = 1; end
          m_state = M_POINT; m_left = POINT_FRAMES;
        end else if (pa_ev) m_state = M_PAUSED;
      M_PAUSED:
        if (pa_ev) m_state = M_PLAY;
      M_POINT:
        if (frame_tick) begin
          m_left--;
          if (m_left == 0) begin
            if (m_s1 == WIN_SCORE) begin m_win = 1; m_state = M_OVER; end
            else if (m_s2 == WIN_SCORE) begin m_win = 2; m_state = M_OVER; end
            else begin m_state = M_SERVE; m_left = SERVE_FRAMES; end
          end
        end
      default: m_state = M_IDLE;
    endcase
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start_n;
    hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = pause_n;
  endtask

  function automatic logic [2:0] enables_for(input int st);
    logic r, u, p;
    r = (st == M_IDLE) || (st == M_SERVE) || (st == M_OVER);
    u = (st == M_PLAY);
    p = (st == M_SERVE) || (st == M_PLAY);
    return {r, u, p};
  endfunction

  function automatic logic [16:0] model_vec();
    return {3'(m_state), 4'(m_s1), 4'(m_s2), 2'(m_win), m_sd, enables_for(m_state)};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {game_state, score1, score2, winner, serve_dir, ball_rst, ball_run, paddle_en};
  endfunction

  task automatic step();
    model_edge();
    @(posedge in_clk);
    #1;
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic cyc(input bit st, input bit pa, input bit ft, input bit ml, input bit mr);
    start_n = st; pause_n = pa; frame_tick = ft; miss_left = ml; miss_right = mr;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(game_state), 32'(M_IDLE));
    check({tag, "_scores"}, 32'({score1, score2, winner}), 32'd0);
    check({tag, "_flags"}, 32'({serve_dir, ball_rst, ball_run, paddle_en}), 32'b1100);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st; bit pa; bit ft; bit ml; bit mr;
    int e_state; int e_s1; int e_s2; int e_win; bit e_sd;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit st, input bit pa, input bit ft, input bit ml, input bit mr,
                              input int es, input int e1, input int e2, input int ew, input bit ed);
    vec_t v;
    v.st = st; v.pa = pa; v.ft = ft; v.ml = ml; v.mr = mr;
    v.e_state = es; v.e_s1 = e1; v.e_s2 = e2; v.e_win = ew; v.e_sd = ed;
    tbl.push_back(v);
  endfunction

  initial begin
    //   st pa ft ml mr   state     s1 s2 w sd
    add(0, 1, 0, 0, 0, M_IDLE,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0, M_IDLE,   0, 0, 0, 1);
    add(0, 1, 0, 0, 0, M_SERVE,  0, 0, 0, 1);  // start held: one event, N+2
    add(1, 1, 0, 0, 0, M_SERVE,  0, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_SERVE,  0, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_SERVE,  0, 0, 0, 1);  // two ticks: still SERVE
    add(1, 1, 0, 0, 0, M_SERVE,  0, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_PLAY,   0, 0, 0, 1);  // third tick launches
    add(1, 1, 0, 0, 1, M_POINT,  1, 0, 0, 1);  // miss_right
    add(1, 1, 1, 0, 0, M_POINT,  1, 0, 0, 1);
    add(1, 1, 0, 1, 0, M_POINT,  1, 0, 0, 1);  // miss ignored in POINT
    add(1, 1, 1, 0, 0, M_SERVE,  1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_PLAY,   1, 0, 0, 1);
    add(1, 1, 0, 1, 1, M_POINT,  1, 0, 0, 1);  // double miss: replay
    add(1, 1, 1, 0, 0, M_POINT,  1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_PLAY,   1, 0, 0, 1);
    add(1, 0, 0, 0, 0, M_PLAY,   1, 0, 0, 1);  // pause press
    add(1, 1, 0, 0, 0, M_PLAY,   1, 0, 0, 1);
    add(0, 1, 1, 0, 0, M_PAUSED, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, M_PAUSED, 1, 0, 0, 1);
    add(1, 1, 0, 1, 0, M_PAUSED, 1, 0, 0, 1);  // start edge + miss ignored
    add(1, 0, 0, 0, 0, M_PAUSED, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, M_PAUSED, 1, 0, 0, 1);
    add(1, 1, 0, 0, 0, M_PLAY,   1, 0, 0, 1);
    add(1, 1, 0, 1, 0, M_POINT,  1, 1, 0, 0);  // miss_left
    add(1, 1, 1, 0, 0, M_POINT,  1, 1, 0, 0);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 1, 0, 0);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 1, 0, 0);
    add(1, 1, 1, 0, 0, M_SERVE,  1, 1, 0, 0);
    add(1, 1, 1, 0, 0, M_PLAY,   1, 1, 0, 0);
    add(1, 1, 0, 1, 0, M_POINT,  1, 2, 0, 0);
    add(1, 1, 1, 0, 0, M_POINT,  1, 2, 0, 0);
    add(1, 1, 1, 0, 0, M_OVER,   1, 2, 2, 0);  // player 2 wins
    add(0, 1, 0, 0, 0, M_OVER,   1, 2, 2, 0);
    add(1, 1, 0, 0, 0, M_OVER,   1, 2, 2, 0);
    add(1, 1, 0, 0, 0, M_SERVE,  0, 0, 0, 1);  // restart clears match
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0; start_n = 1'b1; pause_n = 1'b1;
    frame_tick = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    model_reset();
    repeat (2) @(posedge in_clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].pa, tbl[i].ft, tbl[i].ml, tbl[i].mr);
      check($sformatf("tbl%0d_state", i), 32'(game_state), 32'(tbl[i].e_state));
      check($sformatf("tbl%0d_score", i), 32'({score1, score2}), 32'({4'(tbl[i].e_s1), 4'(tbl[i].e_s2)}));
      check($sformatf("tbl%0d_win_sd", i), 32'({winner, serve_dir}), 32'({2'(tbl[i].e_win), tbl[i].e_sd}));
      check($sformatf("tbl%0d_enables", i), 32'({ball_rst, ball_run, paddle_en}),
            32'(enables_for(tbl[i].e_state)));
    end

    // Reset asserted mid-PLAY takes effect without a clock edge.
    repeat (3) cyc(1, 1, 1, 0, 0);
    check("pre_reset_play", 32'(game_state), 32'(M_PLAY));
    #3 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(posedge in_clk);
    #1 reset = 1'b1;

    // Miss and pause edge in the same cycle: the miss wins.
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("restart_serve", 32'(game_state), 32'(M_SERVE));
    repeat (3) cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    check("miss_beats_pause", 32'({game_state, score1}), 32'({3'(M_POINT), 4'd1}));
    cyc(1, 1, 0, 0, 0);
    check("pause_dropped", 32'(game_state), 32'(M_POINT));

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) start_n = ~start_n;
      if ($urandom_range(0, 39) == 0) pause_n = ~pause_n;
      frame_tick = ($urandom_range(0, 2) == 0);
      miss_left  = ($urandom_range(0, 9) == 0);
      miss_right = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        #1 check_reset_outputs("rand_reset");
        model_reset();
        @(posedge in_clk);
        #1 reset = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level match sequencer for the Pong datapath. Owns game state, the scores and serve direction. Gates the paddle controllers and the ball mover with enable and hold strobes. Sits between the button/VGA timing inputs and the paddle, ball and score-display blocks, and counts frame ticks for serve and point delays.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..15.
SERVE_FRAMES, 60, frames the ball is held at centre before launch; must be ≥1.
POINT_FRAMES, 90, frames the play freezes after a miss; must be ≥1.
SCORE_W, 4, score register width; 2^SCORE_W must be greater than WIN_SCORE.

Ports:
in_clk  input  1  system clock (pixel clock domain)
reset  input  1  asynchronous active-low reset
start_n  input  1  start pushbutton, active-low, asynchronous to in_clk
pause_n  input  1  pause pushbutton, active-low, asynchronous
frame_tick  input  1  one-cycle pulse per video frame (end of active area)
miss_left  input  1  one-cycle pulse: ball passed left edge (player 1 missed)
miss_right  input  1  one-cycle pulse: ball passed right edge (player 2 missed)
ball_rst  output  1  hold ball at screen centre (240,320)
ball_run  output  1  ball may advance
serve_dir  output  1  launch direction: 0 = toward left/player 1, 1 = toward right/player 2
paddle_en  output  1  paddle controllers may move
score1  output  SCORE_W  player 1 points
score2  output  SCORE_W  player 2 points
winner  output  2  0 = none, 1 = player 1, 2 = player 2
game_state  output  3  current state encoding (debug/display)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, scores=0, winner=0, serve_dir=1, frame counter=0, synchronizer flops=1. Decoded outputs take their IDLE values. Reset mid-game aborts the match immediately.
- Button inputs: 3-flop chain per button (s1,s2,s3). Falling edge = s3 & ~s2.
- Button latency: if start_n is low at edge N, the state changes at edge N+2. Holding a button produces exactly one event.
- States, encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSED=4, OVER=5. Codes 6 and 7 recover to IDLE.
- Outputs are decoded from registered state only; there is no combinational path from any input.
  - ball_rst=1 in IDLE, SERVE and OVER.
  - ball_run=1 only in PLAY.
  - paddle_en=1 in SERVE and PLAY.
- IDLE: a start edge moves to SERVE. On that transition: scores cleared, winner=0, serve_dir=1, counter=0.
- SERVE:
  - Counter increments on each frame_tick.
  - When a frame_tick arrives with counter==SERVE_FRAMES-1, move to PLAY and clear the counter.
  - SERVE therefore lasts exactly SERVE_FRAMES ticks.
- PLAY:
  - miss_left alone: score2+1, serve_dir=0, move to POINT.
  - miss_right alone: score1+1, serve_dir=1, move to POINT.
  - miss_left and miss_right in the same cycle: scores and serve_dir unchanged, move to POINT (replay).
  - Pause edge (no miss in that cycle): move to PAUSED.
  - A miss in the same cycle as a pause edge: the miss wins and the pause edge is dropped.
- PAUSED:
  - Freezes everything (ball_rst=0, ball_run=0, paddle_en=0). Scores and counter hold.
  - Pause edge returns to PLAY.
  - Start edges, misses and frame_ticks are ignored.
- POINT:
  - Ball frozen at its exit position (ball_rst=0, ball_run=0, paddle_en=0).
  - Counts POINT_FRAMES frame_ticks.
  - On expiry: if score1==WIN_SCORE, winner=1 and move to OVER. Else if score2==WIN_SCORE, winner=2 and move to OVER. Else move to SERVE with counter=0.
- OVER: scores and winner held. A start edge behaves as in IDLE: scores cleared, winner=0, serve_dir=1, move to SERVE.
- Ignored events:
  - Misses outside PLAY.
  - Start edges in SERVE, PLAY, POINT and PAUSED.
  - Pause edges outside PLAY and PAUSED.
- Scores never exceed WIN_SCORE. The game ends at WIN_SCORE, so no wrap is possible.
- Frame counter width is clog2(max(SERVE_FRAMES,POINT_FRAMES))+1 bits. The counter is only active in SERVE and POINT and is cleared on entry to either.

Test Plan:
1. Reset, then start_n low for 5 cycles → exactly one IDLE→SERVE transition, 2 edges after first low sample. ball_rst=1, paddle_en=1, serve_dir=1.
2. With SERVE_FRAMES=3, pulse frame_tick 3 times → PLAY entered on the 3rd tick edge, ball_run=1. After only 2 ticks the state is still SERVE.
3. In PLAY, pulse miss_right → score1=1, serve_dir=1, state POINT. After POINT_FRAMES ticks → SERVE.
4. In PLAY, miss_left and miss_right in the same cycle → scores unchanged, state POINT. A miss pulse in POINT or PAUSED → no score change.
5. In PLAY, pause edge → PAUSED with all enables 0. Frame_ticks and start edges have no effect. A second pause edge → PLAY.
6. With WIN_SCORE=2, two miss_left events → score2=2, winner=2, OVER after POINT delay. Start edge → scores 0, winner 0, SERVE. Reset asserted mid-PLAY → immediate IDLE with all outputs at reset values.
